// File: rtl/lsu_dm_master.sv
// lsu_dm_master: MEM-stage load/store initiator driving a word-wide data memory port.
// Build option MISALIGN_TRAP_EN: reject misaligned word/half accesses instead of masking the low bits.
module lsu_dm_master #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int unsigned ADDR_SPAN = 4096
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        req,
  output logic        ready,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic [31:0] A,
  output logic [31:0] WD,
  input  logic [31:0] RD,
  output logic        RE,
  output logic        WE,
  output logic [31:0] PC
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_RMW, S_WR, S_DONE, S_REJ, S_ERR
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] wlo_q, wlo_d;
  logic [31:0] a_q, a_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] rdata_q, rdata_d;
  logic [32:0] offset;
  logic        out_of_range;
  logic        misaligned;

  function automatic logic [31:0] load_extend(input logic [2:0] o, input logic [1:0] lane,
                                              input logic [31:0] w);
    logic [15:0] h;
    logic [7:0]  b;
    h = lane[1] ? w[31:16] : w[15:0];
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    case (o)
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'h0000, h};
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'h000000, b};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [2:0] o, input logic [1:0] lane,
                                              input logic [15:0] d, input logic [31:0] w);
    logic [31:0] m;
    m = w;
    if (o == OP_SH) begin
      if (lane[1]) m[31:16] = d;
      else         m[15:0]  = d;
    end else begin
      case (lane)
        2'd0:    m[7:0]   = d[7:0];
        2'd1:    m[15:8]  = d[7:0];
        2'd2:    m[23:16] = d[7:0];
        default: m[31:24] = d[7:0];
      endcase
    end
    return m;
  endfunction

  // Borrow out of the 33-bit subtract flags addresses below the window.
  assign offset       = {1'b0, addr} - {1'b0, ADDR_BASE};
  assign out_of_range = offset[32] || (offset[31:0] >= 32'(ADDR_SPAN));

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    misaligned = 1'b0;
    case (op)
      OP_LW, OP_SW:         misaligned = (addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: misaligned = addr[0];
      default:              misaligned = 1'b0;
    endcase
  end
`else
  // Masking is implicit: A drops addr[1:0] and halfword lanes only look at addr[1].
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    lane_d  = lane_q;
    wlo_d   = wlo_q;
    a_d     = a_q;
    wd_d    = wd_q;
    pc_d    = pc_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          op_d   = op;
          lane_d = addr[1:0];
          wlo_d  = wdata[15:0];
          pc_d   = pc;
          if (out_of_range || misaligned) begin
            state_d = S_REJ;
          end else begin
            a_d = {addr[31:2], 2'b00};
            case (op)
              OP_SW: begin
                wd_d    = wdata;
                state_d = S_WR;
              end
              OP_SH, OP_SB: state_d = S_RMW;
              default:      state_d = S_RD;
            endcase
          end
        end
      end
      S_RD: begin
        rdata_d = load_extend(op_q, lane_q, RD);
        state_d = S_DONE;
      end
      // WD doubles as the merge buffer so the write cycle sees a stable word.
      S_RMW: begin
        wd_d    = store_merge(op_q, lane_q, wlo_q, RD);
        state_d = S_WR;
      end
      S_WR:    state_d = S_DONE;
      // Rejects wait one cycle so every non-RMW request completes with the same latency.
      S_REJ:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      op_q    <= 3'd0;
      lane_q  <= 2'd0;
      wlo_q   <= 16'h0000;
      a_q     <= 32'h0;
      wd_q    <= 32'h0;
      pc_q    <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      lane_q  <= lane_d;
      wlo_q   <= wlo_d;
      a_q     <= a_d;
      wd_q    <= wd_d;
      pc_q    <= pc_d;
      rdata_q <= rdata_d;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign RE    = (state_q == S_RD) || (state_q == S_RMW);
  assign WE    = (state_q == S_WR);
  assign done  = (state_q == S_DONE) || (state_q == S_ERR);
  assign err   = (state_q == S_ERR);
  assign A     = a_q;
  assign WD    = wd_q;
  assign PC    = pc_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_lsu_dm_master.sv
// Bench for lsu_dm_master: directed vector table, reset/held-request sequences and
// randomized traffic checked against a byte-array reference model.
module tb_lsu_dm_master;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;
  localparam longint BASE = 0;
  localparam longint SPAN = 4096;

  logic        clk = 1'b0;
  logic        Reset;
  logic        req;
  logic [2:0]  op;
  logic [31:0] addr, wdata, pc;
  logic        ready, done, err, RE, WE;
  logic [31:0] rdata, A, WD, RD, PC;

  lsu_dm_master dut (
    .clk(clk), .Reset(Reset), .req(req), .ready(ready), .op(op), .addr(addr),
    .wdata(wdata), .pc(pc), .rdata(rdata), .done(done), .err(err), .A(A), .WD(WD),
    .RD(RD), .RE(RE), .WE(WE), .PC(PC)
  );

  always #5 clk = ~clk;

  // Memory device: filled once with a known pattern, then written only through WE.
  logic [31:0] mem [0:1023];
  int fill_cnt = 0;

  function automatic logic [31:0] seed_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h0F1E_2D3C;
  endfunction

  always @(posedge clk) begin
    if (fill_cnt < 1024) begin
      mem[fill_cnt[9:0]] <= seed_word(fill_cnt);
      fill_cnt <= fill_cnt + 1;
    end else if (WE) begin
      mem[A[11:2]] <= WD;
    end
  end

  assign RD = RE ? mem[A[11:2]] : 32'h0;

  // Reference model: byte-addressed memory plus the last successful load value.
  logic [7:0]  rmem [0:4095];
  logic [31:0] last_rd;

  function automatic logic [31:0] rm_word(input longint off);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = rmem[off + i];
    return w;
  endfunction

  task automatic model(input logic [2:0] o, input logic [31:0] ad, input logic [31:0] wd,
                       output logic e, output int lat, output int nre, output int nwe,
                       output logic [31:0] rdv, output logic [31:0] wdv);
    int     size;
    longint off;
    longint val;
    size = (o == OP_LW || o == OP_SW) ? 4 : (o == OP_LB || o == OP_LBU || o == OP_SB) ? 1 : 2;
    off  = longint'(ad) - BASE;
    e    = (off < 0) || (off >= SPAN);
`ifdef MISALIGN_TRAP_EN
    e = e || ((off % size) != 0);
`endif
    rdv = last_rd; wdv = 32'h0; nre = 0; nwe = 0; lat = 2;
    if (!e) begin
      off = off - (off % size);
      if (o <= OP_LBU) begin
        val = 0;
        for (int i = 0; i < size; i++) val += longint'(rmem[off + i]) << (8 * i);
        if ((o == OP_LH || o == OP_LB) && val >= (longint'(1) << (8 * size - 1)))
          val -= longint'(1) << (8 * size);
        rdv = val[31:0];
        last_rd = rdv;
        nre = 1;
      end else begin
        for (int i = 0; i < size; i++) rmem[off + i] = wd[8*i +: 8];
        wdv = rm_word(off - (off % 4));
        nwe = 1;
        nre = (size < 4) ? 1 : 0;
        lat = (size < 4) ? 3 : 2;
      end
    end
  endtask

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    nvec++;
    if (act !== want) begin
      nmis++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, want);
    end
  endtask

  int          obs_lat, obs_nre, obs_nwe;
  logic        obs_err, obs_rdy_busy, obs_rdy_next, obs_timeout;
  logic [31:0] obs_rdata, obs_re_a, obs_we_a, obs_wd, obs_pc;

  // Called at a negedge; returns at the negedge after the done cycle.
  task automatic apply(input logic [2:0] o, input logic [31:0] ad, input logic [31:0] wd,
                       input logic [31:0] p);
    int n;
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    obs_timeout = !ready;
    op = o; addr = ad; wdata = wd; pc = p; req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    op = 3'($urandom); addr = $urandom; wdata = $urandom; pc = $urandom;
    obs_lat = 99; obs_nre = 0; obs_nwe = 0; obs_rdy_busy = 1'b0; obs_err = 1'b0;
    obs_rdata = 32'h0; obs_re_a = 32'h0; obs_we_a = 32'h0; obs_wd = 32'h0; obs_pc = 32'h0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (ready) obs_rdy_busy = 1'b1;
      if (RE) begin obs_nre++; obs_re_a = A; end
      if (WE) begin obs_nwe++; obs_we_a = A; obs_wd = WD; end
      if (done) begin
        obs_lat = c; obs_err = err; obs_rdata = rdata; obs_pc = PC;
        break;
      end
    end
    @(negedge clk);
    obs_rdy_next = ready;
  endtask

  task automatic check_txn(input string tag, input logic e, input int lat, input int nre,
                           input int nwe, input logic [31:0] rdv, input logic chk_rd,
                           input logic [31:0] wdv, input logic [31:0] a, input logic [31:0] p);
    chk({tag, "/timeout"}, obs_timeout, 1'b0);
    chk({tag, "/err"}, obs_err, e);
    chk({tag, "/latency"}, obs_lat, lat);
    chk({tag, "/re_cycles"}, obs_nre, nre);
    chk({tag, "/we_cycles"}, obs_nwe, nwe);
    if (chk_rd) chk({tag, "/rdata"}, obs_rdata, rdv);
    if (nwe != 0) begin
      chk({tag, "/wd"}, obs_wd, wdv);
      chk({tag, "/we_addr"}, obs_we_a, a);
    end
    if (nre != 0) chk({tag, "/re_addr"}, obs_re_a, a);
    chk({tag, "/pc"}, obs_pc, p);
    chk({tag, "/ready_busy"}, obs_rdy_busy, 1'b0);
    chk({tag, "/ready_after"}, obs_rdy_next, 1'b1);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nre;
    int          nwe;
    logic [31:0] wd;
  } vec_t;

  vec_t tbl [10];

  task automatic set_vec(input int i, input logic [2:0] o, input logic [31:0] ad,
                         input logic [31:0] wd, input logic c, input logic [31:0] rv,
                         input logic e, input int lat, input int nre, input int nwe,
                         input logic [31:0] wv);
    tbl[i].op = o; tbl[i].addr = ad; tbl[i].wdata = wd; tbl[i].chk_rd = c;
    tbl[i].rdata = rv; tbl[i].err = e; tbl[i].lat = lat; tbl[i].nre = nre;
    tbl[i].nwe = nwe; tbl[i].wd = wv;
  endtask

  initial begin
    logic        me;
    int          ml, mre, mwe, r, bad, nd, nw;
    logic [31:0] mrd, mwd, ad, wd, p, sw;
    logic [2:0]  o;

    Reset = 1'b0; req = 1'b0; op = 3'd0; addr = 32'h0; wdata = 32'h0; pc = 32'h0;
    last_rd = 32'h0;
    for (int w = 0; w < 1024; w++) begin
      sw = seed_word(w);
      for (int i = 0; i < 4; i++) rmem[4*w + i] = sw[8*i +: 8];
    end

    set_vec(0, OP_SW,  32'h10, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 2, 0, 1, 32'hDEADBEEF);
    set_vec(1, OP_LB,  32'h13, 32'h0,        1'b1, 32'hFFFFFFDE, 1'b0, 2, 1, 0, 32'h0);
    set_vec(2, OP_LBU, 32'h13, 32'h0,        1'b1, 32'h000000DE, 1'b0, 2, 1, 0, 32'h0);
    set_vec(3, OP_LH,  32'h12, 32'h0,        1'b1, 32'hFFFFDEAD, 1'b0, 2, 1, 0, 32'h0);
    set_vec(4, OP_LHU, 32'h10, 32'h0,        1'b1, 32'h0000BEEF, 1'b0, 2, 1, 0, 32'h0);
    set_vec(5, OP_SB,  32'h11, 32'h55,       1'b0, 32'h0,        1'b0, 3, 1, 1, 32'hDEAD55EF);
    set_vec(6, OP_SH,  32'h12, 32'h1234,     1'b0, 32'h0,        1'b0, 3, 1, 1, 32'h123455EF);
`ifdef MISALIGN_TRAP_EN
    set_vec(7, OP_SH,  32'h11, 32'h0055,     1'b0, 32'h0,        1'b1, 2, 0, 0, 32'h0);
    set_vec(8, OP_LW,  32'h10, 32'h0,        1'b1, 32'h123455EF, 1'b0, 2, 1, 0, 32'h0);
    set_vec(9, OP_LW,  32'h1000, 32'h0,      1'b1, 32'h123455EF, 1'b1, 2, 0, 0, 32'h0);
`else
    set_vec(7, OP_SH,  32'h11, 32'h0055,     1'b0, 32'h0,        1'b0, 3, 1, 1, 32'h12340055);
    set_vec(8, OP_LW,  32'h10, 32'h0,        1'b1, 32'h12340055, 1'b0, 2, 1, 0, 32'h0);
    set_vec(9, OP_LW,  32'h1000, 32'h0,      1'b1, 32'h12340055, 1'b1, 2, 0, 0, 32'h0);
`endif

    // Reset state, held while the memory pattern loads.
    repeat (1030) @(posedge clk);
    @(negedge clk);
    chk("rst/ready", ready, 1'b1);
    chk("rst/done_err_re_we", {done, err, RE, WE}, 4'b0000);
    chk("rst/A", A, 32'h0);
    chk("rst/WD", WD, 32'h0);
    chk("rst/rdata", rdata, 32'h0);
    chk("rst/PC", PC, 32'h0);
    Reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      p = 32'h0000_0100 + 32'(4 * i);
      apply(tbl[i].op, tbl[i].addr, tbl[i].wdata, p);
      model(tbl[i].op, tbl[i].addr, tbl[i].wdata, me, ml, mre, mwe, mrd, mwd);
      check_txn($sformatf("dir%0d", i), tbl[i].err, tbl[i].lat, tbl[i].nre, tbl[i].nwe,
                tbl[i].rdata, tbl[i].chk_rd, tbl[i].wd, {tbl[i].addr[31:2], 2'b00}, p);
    end

    // Reset asserted during the RMW read of an SB: abandoned with no write.
    op = OP_SB; addr = 32'h21; wdata = 32'hA5; pc = 32'h200; req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    chk("rstmid/re_in_rmw", RE, 1'b1);
    chk("rstmid/a_in_rmw", A, 32'h20);
    #2;
    Reset = 1'b0;
    #1;
    chk("rstmid/re_we_drop", {RE, WE}, 2'b00);
    chk("rstmid/done", done, 1'b0);
    @(negedge clk);
    Reset = 1'b1;
    last_rd = 32'h0;
    #1;
    chk("rstmid/ready", ready, 1'b1);
    chk("rstmid/rdata", rdata, 32'h0);
    chk("rstmid/mem", mem[8], rm_word(32));
    @(negedge clk);

    // Request held high across the busy cycles is taken only once.
    op = OP_SW; addr = 32'h40; wdata = 32'hCAFEF00D; pc = 32'h300; req = 1'b1;
    nd = 0; nw = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (WE) nw++;
      if (done) begin
        nd++;
        req = 1'b0;
      end
    end
    req = 1'b0;
    model(OP_SW, 32'h40, 32'hCAFEF00D, me, ml, mre, mwe, mrd, mwd);
    chk("held/we_pulses", nw, 1);
    chk("held/done_pulses", nd, 1);
    chk("held/mem", mem[16], 32'hCAFEF00D);

    for (int t = 0; t < 250; t++) begin
      o = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 15);
      if (r == 0)      ad = 32'h1000 + 32'($urandom_range(0, 4095));
      else if (r == 1) ad = $urandom;
      else if (r < 12) ad = 32'($urandom_range(0, 63));
      else             ad = 32'($urandom_range(0, 4095));
      wd = $urandom;
      p  = $urandom;
      apply(o, ad, wd, p);
      model(o, ad, wd, me, ml, mre, mwe, mrd, mwd);
      check_txn($sformatf("rnd%0d", t), me, ml, mre, mwe, mrd, 1'b1, mwd, {ad[31:2], 2'b00}, p);
    end

    bad = 0;
    for (int w = 0; w < 1024; w++) if (mem[w] !== rm_word(longint'(4 * w))) bad++;
    chk("mem_final/bad_words", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
